// File: rtl/sram_burst_top.sv
// -----------------------------------------------------------------------------
// sram_burst_top
//
// Serial-load SRAM with a burst controller. A COLS-bit MSB-first shift
// register feeds a hold register. A three-state controller
// (IDLE / WR_BURST / RD_BURST) drives a ROWS x COLS array. Reads go through a
// READ_LAT-deep pipeline, and burst addresses wrap from row ROWS-1 to row 0.
//
// Optional feature, selected by the macro SRAM_PARITY_EN:
//   - Each row stores an even-parity bit.
//   - The parity_err port is added. It is aligned with data_valid.
//
// Ports:
//   clk        : system clock, rising edge
//   arst       : asynchronous reset, active-high (the array is not reset)
//   serial_in  : serial data bit
//   shift      : shift serial_in into the shift register
//   load       : copy the shift register to the hold register
//                (in WR_BURST, also write the next burst word)
//   w_en/r_en  : write / read request (accepted only in IDLE, one at a time)
//   addr       : start row, sampled on an accepted request
//   burst_len  : burst words minus one, sampled on an accepted request
//   busy       : burst in progress, or read words still in flight
//   data_valid : data_out carries a read word this cycle
//   data_out   : read data; holds its last value between words
//   err        : one-cycle pulse after a rejected request
//   parity_err : (SRAM_PARITY_EN only) stored parity mismatch on the read word
// -----------------------------------------------------------------------------
module sram_burst_top #(
  parameter int ROWS     = 16,
  parameter int COLS     = 8,
  parameter int READ_LAT = 1,
  parameter int BURST_W  = 3
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    serial_in,
  input  logic                    shift,
  input  logic                    load,
  input  logic                    w_en,
  input  logic                    r_en,
  input  logic [$clog2(ROWS)-1:0] addr,
  input  logic [BURST_W-1:0]      burst_len,
  output logic                    busy,
  output logic                    data_valid,
  output logic [COLS-1:0]         data_out,
`ifdef SRAM_PARITY_EN
  output logic                    parity_err,
`endif
  output logic                    err
);

  localparam int AW = $clog2(ROWS);
`ifdef SRAM_PARITY_EN
  localparam int MW = COLS + 1;
`else
  localparam int MW = COLS;
`endif

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t             state, state_d;
  logic [AW-1:0]      ptr, ptr_d;
  logic [BURST_W-1:0] rem, rem_d;

  logic [COLS-1:0]    sr, hold;
  logic [MW-1:0]      mem [ROWS];

  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [COLS-1:0]    mem_wdata;
  logic               rd_vld_p0;
  logic [AW-1:0]      rd_row_p0;
  logic [MW-1:0]      rd_word_p0;
  logic               err_d;

  logic               last_vld;
  logic [MW-1:0]      last_word;
  logic               rd_inflight;

  // Stored word format: data, with the even-parity bit on top when enabled.
  function automatic logic [MW-1:0] pack_word(input logic [COLS-1:0] d);
`ifdef SRAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Serial front end. It runs regardless of controller state. On a
  // simultaneous shift and load, hold captures sr's pre-shift value.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sr   <= '0;
      hold <= '0;
    end else begin
      if (shift) sr   <= {sr[COLS-2:0], serial_in};
      if (load)  hold <= sr;
    end
  end

  // Controller state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      rem   <= rem_d;
    end
  end

  // Next-state logic. rem counts the words still to come after the first one.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    rem_d   = rem;
    case (state)
      IDLE: begin
        if (w_en ^ r_en) begin
          ptr_d = addr + AW'(1);
          rem_d = burst_len;
          if (burst_len != '0) state_d = w_en ? WR_BURST : RD_BURST;
        end
      end
      WR_BURST: begin
        if (load) begin
          ptr_d = ptr + AW'(1);
          rem_d = rem - BURST_W'(1);
          if (rem == BURST_W'(1)) state_d = IDLE;
        end
      end
      RD_BURST: begin
        ptr_d = ptr + AW'(1);
        rem_d = rem - BURST_W'(1);
        if (rem == BURST_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode. In IDLE, the first burst word comes from hold. Later
  // burst words come straight from sr on each load.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr;
    mem_wdata = sr;
    rd_vld_p0 = 1'b0;
    rd_row_p0 = ptr;
    err_d     = 1'b0;
    case (state)
      IDLE: begin
        if (w_en && r_en) begin
          err_d = 1'b1;
        end else if (w_en) begin
          mem_we    = 1'b1;
          mem_waddr = addr;
          mem_wdata = hold;
        end else if (r_en) begin
          rd_vld_p0 = 1'b1;
          rd_row_p0 = addr;
        end
      end
      WR_BURST: begin
        err_d  = w_en | r_en;
        mem_we = load;
      end
      RD_BURST: begin
        err_d     = w_en | r_en;
        rd_vld_p0 = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) err <= 1'b0;
    else      err <= err_d;
  end

  // Storage array. It has no reset, so contents survive arst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= pack_word(mem_wdata);
  end

  // Stage p0: the read is issued. The array is read combinationally, so a
  // write committed on the previous edge is already visible.
  assign rd_word_p0 = mem[rd_row_p0];

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign last_vld    = rd_vld_p0;
      assign last_word   = rd_word_p0;
      assign rd_inflight = 1'b0;
    end else begin : g_latn
      logic [READ_LAT-1:1] rd_vld_p;
      logic [MW-1:0]       rd_dat_p [1:READ_LAT-1];

      // Stages p1 .. p(READ_LAT-1): valid is flushed by reset, data is not.
      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          rd_vld_p <= '0;
        end else begin
          rd_vld_p[1] <= rd_vld_p0;
          for (int k = 2; k < READ_LAT; k++) rd_vld_p[k] <= rd_vld_p[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rd_vld_p0) rd_dat_p[1] <= rd_word_p0;
        for (int k = 2; k < READ_LAT; k++)
          if (rd_vld_p[k-1]) rd_dat_p[k] <= rd_dat_p[k-1];
      end

      assign last_vld    = rd_vld_p[READ_LAT-1];
      assign last_word   = rd_dat_p[READ_LAT-1];
      assign rd_inflight = |rd_vld_p;
    end
  endgenerate

  // Output stage: data_out only updates on a valid word, so it holds its
  // last value between words.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      data_valid <= 1'b0;
      data_out   <= '0;
`ifdef SRAM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      data_valid <= last_vld;
      if (last_vld) data_out <= last_word[COLS-1:0];
`ifdef SRAM_PARITY_EN
      // Even parity over data and stored bit is zero for an intact word.
      parity_err <= last_vld & (^last_word);
`endif
    end
  end

  assign busy = (state != IDLE) || rd_inflight || data_valid;

endmodule

// File: tb/tb_sram_burst_top.sv
module tb_sram_burst_top;
  localparam int ROWS     = 16;
  localparam int COLS     = 8;
  localparam int READ_LAT = 1;
  localparam int BURST_W  = 3;

  logic       clk = 1'b0;
  logic       arst, serial_in, shift, load, w_en, r_en;
  logic [3:0] addr;
  logic [2:0] burst_len;
  logic       busy, data_valid, err;
  logic [7:0] data_out;
`ifdef SRAM_PARITY_EN
  logic       parity_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_burst_top #(.ROWS(ROWS), .COLS(COLS), .READ_LAT(READ_LAT), .BURST_W(BURST_W)) dut (
    .clk(clk), .arst(arst), .serial_in(serial_in), .shift(shift), .load(load),
    .w_en(w_en), .r_en(r_en), .addr(addr), .burst_len(burst_len),
    .busy(busy), .data_valid(data_valid), .data_out(data_out),
`ifdef SRAM_PARITY_EN
    .parity_err(parity_err),
`endif
    .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_IDLE, M_WR, M_RD} mmode_t;
  mmode_t     m_mode;
  logic [7:0] mmem [16];
  bit         mpar [16];
  logic [7:0] m_sr, m_hold;
  logic [3:0] m_ptr;
  int         m_left;
  int         pipe[$];  // in-flight reads: {valid, parity_err, data}
  logic       exp_dv, exp_err, exp_busy, exp_perr;
  logic [7:0] exp_dout;

  always @(posedge clk or posedge arst) begin
    bit         iss, e, anyv;
    logic [3:0] irow;
    int         ent;
    if (arst) begin
      m_mode = M_IDLE; m_sr = '0; m_hold = '0; m_ptr = '0; m_left = 0;
      pipe.delete();
      for (int i = 0; i < READ_LAT - 1; i++) pipe.push_back(0);
      exp_dv = 0; exp_dout = '0; exp_err = 0; exp_busy = 0; exp_perr = 0;
    end else begin
      iss = 0; e = 0; irow = '0;
      case (m_mode)
        M_IDLE: begin
          if (w_en && r_en) e = 1;
          else if (w_en) begin
            mmem[addr] = m_hold; mpar[addr] = ^m_hold;
            if (burst_len != 0) begin m_mode = M_WR; m_ptr = addr + 4'd1; m_left = int'(burst_len); end
          end else if (r_en) begin
            iss = 1; irow = addr;
            if (burst_len != 0) begin m_mode = M_RD; m_ptr = addr + 4'd1; m_left = int'(burst_len); end
          end
        end
        M_WR: begin
          e = w_en | r_en;
          if (load) begin
            mmem[m_ptr] = m_sr; mpar[m_ptr] = ^m_sr;
            m_ptr = m_ptr + 4'd1; m_left--;
            if (m_left == 0) m_mode = M_IDLE;
          end
        end
        default: begin
          e = w_en | r_en;
          iss = 1; irow = m_ptr;
          m_ptr = m_ptr + 4'd1; m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      endcase
      ent = 0;
      if (iss) ent = (1 << 9) | (int'((^mmem[irow]) != mpar[irow]) << 8) | int'(mmem[irow]);
      pipe.push_back(ent);
      ent = pipe.pop_front();
      exp_dv   = ent[9];
      exp_perr = ent[9] & ent[8];
      if (ent[9]) exp_dout = ent[7:0];
      exp_err = e;
      anyv = 0;
      foreach (pipe[i]) if (pipe[i][9]) anyv = 1;
      exp_busy = (m_mode != M_IDLE) || anyv || exp_dv;
      if (load)  m_hold = m_sr;
      if (shift) m_sr = {m_sr[6:0], serial_in};
    end
  end

  // Compare process: all outputs against the model on every cycle.
  always @(negedge clk) begin
    chk("data_valid", 32'(data_valid), 32'(exp_dv));
    chk("data_out",   32'(data_out),   32'(exp_dout));
    chk("err",        32'(err),        32'(exp_err));
    chk("busy",       32'(busy),       32'(exp_busy));
`ifdef SRAM_PARITY_EN
    chk("parity_err", 32'(parity_err), 32'(exp_perr));
`endif
  end

  // ---------------- stimulus ----------------
  logic [7:0] lit_q[$];

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      serial_in = b[i]; shift = 1'b1;
      @(negedge clk);
    end
    shift = 1'b0; serial_in = 1'b0;
  endtask

  task automatic put_word(input logic [7:0] b);
    shift_byte(b);
    load = 1'b1; @(negedge clk); load = 1'b0;
  endtask

  task automatic req_write(input logic [3:0] a, input logic [2:0] l);
    w_en = 1'b1; addr = a; burst_len = l;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic read_chk(input logic [3:0] a, input logic [2:0] l, input string tag);
    int n;
    r_en = 1'b1; addr = a; burst_len = l;
    @(negedge clk);
    r_en = 1'b0; n = 1;
    while (!data_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, 32'(n), 32'(READ_LAT));
    for (int i = 0; i <= int'(l); i++) begin
      chk({tag, "_dv"},   32'(data_valid), 32'(1));
      chk({tag, "_data"}, 32'(data_out),   32'(lit_q[i]));
      @(negedge clk);
    end
  endtask

  initial begin
    int seen, g, dvc;
    arst = 1'b1; serial_in = 0; shift = 0; load = 0; w_en = 0; r_en = 0;
    addr = '0; burst_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_dout", 32'(data_out), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_dv",   32'(data_valid), 32'(0));
    #2 arst = 1'b0;
    @(negedge clk);

    // Fill every row: row i = i*0x11.
    put_word(8'h00); req_write(4'd0, 3'd7);
    for (int i = 1; i < 8; i++) put_word(8'(i * 17));
    put_word(8'h88); req_write(4'd8, 3'd7);
    for (int i = 9; i < 16; i++) put_word(8'(i * 17));
    chk("model_row3", 32'(mmem[3]), 32'h33);
    chk("model_row12", 32'(mmem[12]), 32'hCC);

    // Single write / read.
    put_word(8'hA5); req_write(4'd2, 3'd0);
    chk("model_row2", 32'(mmem[2]), 32'hA5);
    lit_q = '{8'hA5}; read_chk(4'd2, 3'd0, "single");

    // Write burst with wrap-around.
    put_word(8'h11); req_write(4'd14, 3'd3);
    chk("wr_busy", 32'(busy), 32'(1));
    put_word(8'h22); put_word(8'h33); put_word(8'h44);
    chk("wr_done_busy", 32'(busy), 32'(0));
    chk("model_row14", 32'(mmem[14]), 32'h11);
    chk("model_row15", 32'(mmem[15]), 32'h22);
    chk("model_row0",  32'(mmem[0]),  32'h33);
    chk("model_row1",  32'(mmem[1]),  32'h44);
    lit_q = '{8'h11, 8'h22, 8'h33, 8'h44}; read_chk(4'd14, 3'd3, "wrap");

    // Conflict in IDLE: array must stay unchanged.
    w_en = 1'b1; r_en = 1'b1; addr = 4'd2; burst_len = 3'd0;
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
    chk("conf_err", 32'(err), 32'(1));
    @(negedge clk);
    chk("conf_err_pulse", 32'(err), 32'(0));
    lit_q = '{8'hA5}; read_chk(4'd2, 3'd0, "conf_keep");

    // r_en during a write burst: rejected, the burst still completes.
    put_word(8'h66); req_write(4'd5, 3'd1);
    r_en = 1'b1; addr = 4'd9; @(negedge clk); r_en = 1'b0;
    chk("wrb_err", 32'(err), 32'(1));
    put_word(8'h77);
    lit_q = '{8'h66, 8'h77}; read_chk(4'd5, 3'd1, "wrb");

    // Read-after-write on the next cycle.
    put_word(8'h5A); req_write(4'd7, 3'd0);
    lit_q = '{8'h5A}; read_chk(4'd7, 3'd0, "raw");

    // Reset in the middle of a read burst.
    r_en = 1'b1; addr = 4'd0; burst_len = 3'd7;
    @(negedge clk);
    r_en = 1'b0; seen = 0; g = 0;
    while (g < 20) begin
      if (data_valid) seen++;
      if (seen == 3) break;
      @(negedge clk); g++;
    end
    chk("rst_seen", 32'(seen), 32'(3));
    #2 arst = 1'b1;
    #1;
    chk("rst_mid_dv",   32'(data_valid), 32'(0));
    chk("rst_mid_busy", 32'(busy), 32'(0));
    @(negedge clk);
    #2 arst = 1'b0;
    dvc = 0;
    repeat (12) begin @(negedge clk); if (data_valid) dvc++; end
    chk("rst_no_more", 32'(dvc), 32'(0));
    lit_q = '{8'hA5}; read_chk(4'd2, 3'd0, "rst_keep");

`ifdef SRAM_PARITY_EN
    dut.mem[3][0] = ~dut.mem[3][0];
    mmem[3][0] = ~mmem[3][0];
    r_en = 1'b1; addr = 4'd3; burst_len = 3'd0;
    @(negedge clk);
    r_en = 1'b0;
    repeat (READ_LAT - 1) @(negedge clk);
    chk("par_flip", 32'(parity_err), 32'(1));
    @(negedge clk);
    r_en = 1'b1; addr = 4'd4;
    @(negedge clk);
    r_en = 1'b0;
    repeat (READ_LAT - 1) @(negedge clk);
    chk("par_clean", 32'(parity_err), 32'(0));
    @(negedge clk);
`endif

    // Randomised traffic, checked cycle by cycle by the compare process.
    for (int c = 0; c < 800; c++) begin
      serial_in = ($urandom_range(0, 1) == 1);
      shift     = ($urandom_range(0, 1) == 1);
      load      = ($urandom_range(0, 3) == 0);
      w_en      = ($urandom_range(0, 7) == 0);
      r_en      = ($urandom_range(0, 7) == 0);
      addr      = 4'($urandom_range(0, 15));
      burst_len = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    w_en = 0; r_en = 0; shift = 0;
    load = 1'b1; repeat (10) @(negedge clk); load = 1'b0;
    repeat (10) @(negedge clk);
    chk("drain_busy", 32'(busy), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
